// File: rtl/bullet_scheduler_if.sv
// ---------------------------------------------------------------------------
// bullet_scheduler_if
// Bundles the player/collision inputs and the bullet state outputs of
// bullet_scheduler.
//   shoot_req      fire button level, sampled once per frame
//   player_X       player centre X (10-bit unsigned pixels)
//   hit_valid      collision logic reports a bullet hit this frame
//   hit_slot       slot (0/1) of the bullet that hit, valid with hit_valid
//   bullet0_X/Y    slot 0 position (0/0 while inactive)
//   bullet1_X/Y    slot 1 position (0/0 while inactive)
//   bullet_active  bit i high = slot i in flight
//   fire_ack       one-frame pulse on the frame a bullet is launched
// Modports: master = game/player side, slave = the scheduler.
// ---------------------------------------------------------------------------
interface bullet_scheduler_if;
  logic       shoot_req;
  logic [9:0] player_X;
  logic       hit_valid;
  logic       hit_slot;
  logic [9:0] bullet0_X;
  logic [9:0] bullet0_Y;
  logic [9:0] bullet1_X;
  logic [9:0] bullet1_Y;
  logic [1:0] bullet_active;
  logic       fire_ack;

  modport master (
    output shoot_req, player_X, hit_valid, hit_slot,
    input  bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, bullet_active, fire_ack
  );

  modport slave (
    input  shoot_req, player_X, hit_valid, hit_slot,
    output bullet0_X, bullet0_Y, bullet1_X, bullet1_Y, bullet_active, fire_ack
  );
endinterface

// File: rtl/bullet_scheduler.sv
// ---------------------------------------------------------------------------
// bullet_scheduler
// Two-slot player bullet manager, updated once per frame.
//   frame_clk  frame-rate clock, all state changes on its rising edge
//   Reset      asynchronous, active-high; clears bullets and fire lockout
//   bus        bullet_scheduler_if.slave (fire request, player X, hit
//              report in; bullet positions, active mask, fire_ack out)
// A shot loads the lowest free slot with (player_X, BULLET_Y_START) and locks
// out further shots for COOLDOWN frames. Active bullets climb BULLET_STEP
// pixels per frame and retire near BULLET_Y_MIN; a hit clears its slot.
// Build option: define BULLET_AUTOFIRE_EN to fire on the shoot_req level
// (held button auto-repeats) instead of on its rising edge.
// ---------------------------------------------------------------------------
module bullet_scheduler #(
  parameter logic [9:0] BULLET_Y_START = 10'd440,
  parameter logic [9:0] BULLET_STEP    = 10'd4,
  parameter logic [9:0] BULLET_Y_MIN   = 10'd0,
  parameter logic [9:0] COOLDOWN       = 10'd15
) (
  input logic               frame_clk,
  input logic               Reset,
  bullet_scheduler_if.slave bus
);

  typedef enum logic [0:0] {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  // Widened so BULLET_Y_MIN + BULLET_STEP can never wrap.
  localparam logic [10:0] RETIRE_LIMIT = {1'b0, BULLET_Y_MIN} + {1'b0, BULLET_STEP};

  state_t     state_reg, state_next;
  logic [9:0] cool_cnt_reg, cool_cnt_next;
  logic       shoot_prev_reg;
  logic       ack_reg;

  logic       trigger;
  logic       fire;
  logic       fire_slot;
  logic [1:0] active_vec;
  logic [1:0][9:0] x_vec;
  logic [1:0][9:0] y_vec;

`ifdef BULLET_AUTOFIRE_EN
  assign trigger = bus.shoot_req;
`else
  assign trigger = bus.shoot_req & ~shoot_prev_reg;
`endif

  // State register, lockout counter, shoot edge history and fire_ack.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= ST_READY;
      cool_cnt_reg   <= 10'd0;
      shoot_prev_reg <= 1'b0;
      ack_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cool_cnt_reg   <= cool_cnt_next;
      shoot_prev_reg <= bus.shoot_req;
      ack_reg        <= fire;
    end
  end

  // Next state: a launch starts the lockout; the edge on which the counter
  // reaches zero returns to READY, so the next shot lands COOLDOWN+1 frames
  // after the previous one.
  always_comb begin
    state_next    = state_reg;
    cool_cnt_next = cool_cnt_reg;
    case (state_reg)
      ST_READY: begin
        if (fire) begin
          state_next    = ST_COOLDOWN;
          cool_cnt_next = COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cool_cnt_reg <= 10'd1) begin
          state_next    = ST_READY;
          cool_cnt_next = 10'd0;
        end else begin
          cool_cnt_next = cool_cnt_reg - 10'd1;
        end
      end
      default: begin
        state_next    = ST_READY;
        cool_cnt_next = 10'd0;
      end
    endcase
  end

  // Fire decision: only slots free before this edge count, so a slot
  // cleared by a hit or retirement this edge is not reused until the next.
  always_comb begin
    fire      = 1'b0;
    fire_slot = 1'b0;
    if (state_reg == ST_READY && trigger && !(&active_vec)) begin
      fire      = 1'b1;
      fire_slot = active_vec[0];  // lowest-index free slot
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : slot_g
      localparam logic SLOT_ID = 1'(gi);

      logic       active_reg;
      logic [9:0] x_reg;
      logic [9:0] y_reg;
      logic       launch;
      logic       hit_here;
      logic       retire;

      assign launch   = fire && (fire_slot == SLOT_ID);
      assign hit_here = bus.hit_valid && (bus.hit_slot == SLOT_ID);
      // Compare before subtracting so Y never underflows.
      assign retire   = ({1'b0, y_reg} < RETIRE_LIMIT);

      // Launch only targets an inactive slot, so it never competes with a
      // hit or retirement; hit outranks motion; inactive slots rest at 0/0.
      always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
          active_reg <= 1'b0;
          x_reg      <= 10'd0;
          y_reg      <= 10'd0;
        end else if (launch) begin
          active_reg <= 1'b1;
          x_reg      <= bus.player_X;
          y_reg      <= BULLET_Y_START;
        end else if (active_reg && (hit_here || retire)) begin
          active_reg <= 1'b0;
          x_reg      <= 10'd0;
          y_reg      <= 10'd0;
        end else if (active_reg) begin
          y_reg <= y_reg - BULLET_STEP;
        end
      end

      assign active_vec[gi] = active_reg;
      assign x_vec[gi]      = x_reg;
      assign y_vec[gi]      = y_reg;
    end
  endgenerate

  assign bus.bullet_active = active_vec;
  assign bus.bullet0_X     = x_vec[0];
  assign bus.bullet0_Y     = y_vec[0];
  assign bus.bullet1_X     = x_vec[1];
  assign bus.bullet1_Y     = y_vec[1];
  assign bus.fire_ack      = ack_reg;

endmodule

// File: tb/tb_bullet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bullet_scheduler
// Directed bench for bullet_scheduler. A frame-level model (edge numbers,
// "next allowed fire edge", per-slot position lists) predicts every output
// and is compared on each falling edge; literal checks pin key frames.
// A second instance with BULLET_Y_START=11 exercises the Y=3 retirement.
// ---------------------------------------------------------------------------
module tb_bullet_scheduler;
  localparam int Y_START = 440;
  localparam int STEP    = 4;
  localparam int Y_MIN   = 0;
  localparam int COOL    = 15;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  bullet_scheduler_if bus ();
  bullet_scheduler_if bus2 ();

  bullet_scheduler u_dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  bullet_scheduler #(.BULLET_Y_START(10'd11)) u_dut2 (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus2.slave)
  );

  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit m_active [2];
  int m_x      [2];
  int m_y      [2];
  bit m_ack;
  bit m_prev;
  int m_edge;   // number of the last frame edge since reset release
  int m_allow;  // first edge number on which a shot may launch

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 2; i++) begin
        m_active[i] = 1'b0;
        m_x[i] = 0;
        m_y[i] = 0;
      end
      m_ack   = 1'b0;
      m_prev  = 1'b0;
      m_edge  = 0;
      m_allow = 1;
    end else begin
      bit trig;
      int slot;
      m_edge++;
`ifdef BULLET_AUTOFIRE_EN
      trig = bus.shoot_req;
`else
      trig = bus.shoot_req && !m_prev;
`endif
      m_prev = bus.shoot_req;
      slot = -1;
      if (trig && m_edge >= m_allow) begin
        if (!m_active[0]) slot = 0;
        else if (!m_active[1]) slot = 1;
      end
      m_ack = (slot >= 0);
      if (m_ack) m_allow = m_edge + COOL + 1;
      for (int i = 0; i < 2; i++) begin
        if (i == slot) begin
          m_active[i] = 1'b1;
          m_x[i] = int'(bus.player_X);
          m_y[i] = Y_START;
        end else if (m_active[i] && bus.hit_valid && int'(bus.hit_slot) == i) begin
          m_active[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end else if (m_active[i] && m_y[i] < Y_MIN + STEP) begin
          m_active[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end else if (m_active[i]) begin
          m_y[i] = m_y[i] - STEP;
        end
      end
    end
  end

  // Compare process: outputs are meaningful on every frame out of reset.
  always @(negedge frame_clk) begin
    if (!Reset) begin
      check("cmp_active", 32'(bus.bullet_active), 32'({m_active[1], m_active[0]}));
      check("cmp_ack",    32'(bus.fire_ack),  32'(m_ack));
      check("cmp_b0X",    32'(bus.bullet0_X), m_x[0]);
      check("cmp_b0Y",    32'(bus.bullet0_Y), m_y[0]);
      check("cmp_b1X",    32'(bus.bullet1_X), m_x[1]);
      check("cmp_b1Y",    32'(bus.bullet1_Y), m_y[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic go_to_edge(input int n);
    int guard;
    guard = 0;
    while (m_edge < n && guard < 2000) begin
      @(negedge frame_clk);
      guard++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(bus.bullet_active), 0);
    check({tag, "_ack"},    32'(bus.fire_ack), 0);
    check({tag, "_b0X"},    32'(bus.bullet0_X), 0);
    check({tag, "_b0Y"},    32'(bus.bullet0_Y), 0);
    check({tag, "_b1X"},    32'(bus.bullet1_X), 0);
    check({tag, "_b1Y"},    32'(bus.bullet1_Y), 0);
  endtask

  // Called with two bullets in flight and the lockout running.
  task automatic reset_mid_flight();
    #2 Reset = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge frame_clk);
    Reset = 1'b0;
    bus.shoot_req = 1'b1;
    bus.player_X  = 10'd7;
    @(negedge frame_clk);
    check("post_rst_active", 32'(bus.bullet_active), 32'h1);
    check("post_rst_ack",    32'(bus.fire_ack), 1);
    check("post_rst_b0X",    32'(bus.bullet0_X), 7);
    check("post_rst_b0Y",    32'(bus.bullet0_Y), 440);
    bus.shoot_req = 1'b0;
    repeat (3) @(negedge frame_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.shoot_req  = 1'b0;
    bus.player_X   = 10'd0;
    bus.hit_valid  = 1'b0;
    bus.hit_slot   = 1'b0;
    bus2.shoot_req = 1'b0;
    bus2.player_X  = 10'd0;
    bus2.hit_valid = 1'b0;
    bus2.hit_slot  = 1'b0;

    repeat (2) @(negedge frame_clk);
    check_all_zero("reset");

`ifdef BULLET_AUTOFIRE_EN
    // Held button: launches at edges 1 and 17; a hit at 32 frees slot 0
    // so the ready frame 33 launches again.
    Reset = 1'b0;
    bus.shoot_req = 1'b1;
    bus.player_X  = 10'd50;
    @(negedge frame_clk);
    check("af_e1_ack",    32'(bus.fire_ack), 1);
    check("af_e1_active", 32'(bus.bullet_active), 32'h1);
    go_to_edge(2);
    check("af_e2_ack",    32'(bus.fire_ack), 0);
    go_to_edge(17);
    check("af_e17_ack",    32'(bus.fire_ack), 1);
    check("af_e17_active", 32'(bus.bullet_active), 32'h3);
    go_to_edge(31);
    bus.hit_valid = 1'b1;
    bus.hit_slot  = 1'b0;
    go_to_edge(32);
    check("af_e32_active", 32'(bus.bullet_active), 32'h2);
    bus.hit_valid = 1'b0;
    go_to_edge(33);
    check("af_e33_ack",    32'(bus.fire_ack), 1);
    check("af_e33_active", 32'(bus.bullet_active), 32'h3);
    check("af_e33_b0Y",    32'(bus.bullet0_Y), 440);
    go_to_edge(40);
    bus.shoot_req = 1'b0;
    go_to_edge(42);
    reset_mid_flight();
`else
    // First shot on the first edge after release.
    Reset = 1'b0;
    bus.player_X  = 10'd320;
    bus.shoot_req = 1'b1;
    @(negedge frame_clk);
    check("e1_active", 32'(bus.bullet_active), 32'h1);
    check("e1_b0X",    32'(bus.bullet0_X), 320);
    check("e1_b0Y",    32'(bus.bullet0_Y), 440);
    check("e1_ack",    32'(bus.fire_ack), 1);
    bus.shoot_req = 1'b0;
    @(negedge frame_clk);
    check("e2_b0Y", 32'(bus.bullet0_Y), 436);
    check("e2_ack", 32'(bus.fire_ack), 0);

    // Edge during lockout is lost; edge at k+16 launches slot 1.
    go_to_edge(5);
    bus.shoot_req = 1'b1;
    go_to_edge(6);
    check("e6_ack",    32'(bus.fire_ack), 0);
    check("e6_active", 32'(bus.bullet_active), 32'h1);
    bus.shoot_req = 1'b0;
    go_to_edge(16);
    bus.shoot_req = 1'b1;
    bus.player_X  = 10'd100;
    go_to_edge(17);
    check("e17_ack",    32'(bus.fire_ack), 1);
    check("e17_active", 32'(bus.bullet_active), 32'h3);
    check("e17_b1X",    32'(bus.bullet1_X), 100);
    check("e17_b1Y",    32'(bus.bullet1_Y), 440);
    check("e17_b0Y",    32'(bus.bullet0_Y), 376);
    bus.shoot_req = 1'b0;

    // Both slots full: request dropped. Then hit slot 0, relaunch next frame.
    go_to_edge(33);
    bus.shoot_req = 1'b1;
    go_to_edge(34);
    check("e34_ack",    32'(bus.fire_ack), 0);
    check("e34_active", 32'(bus.bullet_active), 32'h3);
    bus.shoot_req = 1'b0;
    bus.hit_valid = 1'b1;
    bus.hit_slot  = 1'b0;
    go_to_edge(35);
    check("e35_active", 32'(bus.bullet_active), 32'h2);
    check("e35_b0Y",    32'(bus.bullet0_Y), 0);
    check("e35_b1Y",    32'(bus.bullet1_Y), 368);
    bus.hit_valid = 1'b0;
    bus.shoot_req = 1'b1;
    bus.player_X  = 10'd500;
    go_to_edge(36);
    check("e36_ack",    32'(bus.fire_ack), 1);
    check("e36_active", 32'(bus.bullet_active), 32'h3);
    check("e36_b0X",    32'(bus.bullet0_X), 500);
    check("e36_b0Y",    32'(bus.bullet0_Y), 440);
    bus.shoot_req = 1'b0;

    // Second instance: 11 -> 7 -> 3 -> retired, no wrap.
    go_to_edge(40);
    bus2.shoot_req = 1'b1;
    bus2.player_X  = 10'd9;
    go_to_edge(41);
    check("y3_launch_ack", 32'(bus2.fire_ack), 1);
    check("y3_launch_Y",   32'(bus2.bullet0_Y), 11);
    bus2.shoot_req = 1'b0;
    go_to_edge(43);
    check("y3_Y",      32'(bus2.bullet0_Y), 3);
    check("y3_active", 32'(bus2.bullet_active), 32'h1);
    go_to_edge(44);
    check("y3_ret_active", 32'(bus2.bullet_active), 32'h0);
    check("y3_ret_Y",      32'(bus2.bullet0_Y), 0);
    check("y3_ret_X",      32'(bus2.bullet0_X), 0);

    // Slot 1 reaches Y=0 at edge 127 and retires at 128.
    go_to_edge(127);
    check("e127_b1Y",    32'(bus.bullet1_Y), 0);
    check("e127_active", 32'(bus.bullet_active), 32'h3);
    go_to_edge(128);
    check("e128_active", 32'(bus.bullet_active), 32'h1);
    check("e128_b1Y",    32'(bus.bullet1_Y), 0);

    // Hit on an inactive slot is ignored.
    bus.hit_valid = 1'b1;
    bus.hit_slot  = 1'b1;
    go_to_edge(129);
    check("e129_active", 32'(bus.bullet_active), 32'h1);
    check("e129_b0Y",    32'(bus.bullet0_Y), 68);
    bus.hit_valid = 1'b0;

    // Second bullet, then reset while in flight and locked out.
    bus.shoot_req = 1'b1;
    bus.player_X  = 10'd200;
    go_to_edge(130);
    check("e130_ack",    32'(bus.fire_ack), 1);
    check("e130_active", 32'(bus.bullet_active), 32'h3);
    bus.shoot_req = 1'b0;
    go_to_edge(133);
    reset_mid_flight();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
